// File: rtl/tank_link_if.sv
// tank_link_if: valid/ready word handshake between game logic (master) and tank_link_tx (slave).
//   tx_data  : word to send, DATA_W bits
//   tx_valid : master has a word
//   tx_ready : slave can accept a word
interface tank_link_if #(parameter int DATA_W = 16);
   logic [DATA_W-1:0] tx_data;
   logic              tx_valid;
   logic              tx_ready;
   modport master (output tx_data, tx_valid, input tx_ready);
   modport slave  (input tx_data, tx_valid, output tx_ready);
endinterface

// File: rtl/tank_link_tx.sv
// tank_link_tx: idle-high LSB-first serial frame transmitter paced by an asynchronous bit clock.
//   clk, rst  : system clock, synchronous active-high reset
//   tick_clk  : divided bit clock, each rising edge marks one bit period
//   link      : tank_link_if.slave handshake (tx_data, tx_valid, tx_ready)
//   tx_line   : registered serial output, idle high
//   busy      : frame in progress
// Optional: define TANK_LINK_PARITY_EN to append an even parity bit before the stop bits.
module tank_link_tx #(
   parameter int DATA_W    = 16,
   parameter int STOP_BITS = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         tick_clk,
   tank_link_if.slave   link,
   output logic         tx_line,
   output logic         busy
);
   localparam int CNT_W = $clog2(DATA_W);
   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] ARMED  = 3'd1;
   localparam logic [2:0] START  = 3'd2;
   localparam logic [2:0] DATA   = 3'd3;
`ifdef TANK_LINK_PARITY_EN
   localparam logic [2:0] PARITY = 3'd4;
`endif
   localparam logic [2:0] STOP   = 3'd5;
   logic [2:0]        state;
   logic              s1, s2, s2_d;
   logic              tick;
   logic [DATA_W-1:0] shift;
   logic [CNT_W-1:0]  bit_cnt;
   logic              stop_cnt;
`ifdef TANK_LINK_PARITY_EN
   logic              par;
`endif
   // Rising edge of the synchronised bit clock, one clk wide.
   assign tick          = s2 & ~s2_d;
   assign link.tx_ready = state == IDLE;
   assign busy          = state != IDLE;
   always_ff @(posedge clk) begin
      if (rst) begin
         s1       <= 1'b0;
         s2       <= 1'b0;
         s2_d     <= 1'b0;
         state    <= IDLE;
         tx_line  <= 1'b1;
         shift    <= '0;
         bit_cnt  <= '0;
         stop_cnt <= 1'b0;
`ifdef TANK_LINK_PARITY_EN
         par      <= 1'b0;
`endif
      end else begin
         s1   <= tick_clk;
         s2   <= s1;
         s2_d <= s2;
         case (state)
            IDLE: if (link.tx_valid) begin
               shift   <= link.tx_data;
               bit_cnt <= '0;
`ifdef TANK_LINK_PARITY_EN
               par     <= ^link.tx_data;
`endif
               state   <= ARMED;
            end
            // Waiting here aligns the start bit to a full tick period.
            ARMED: if (tick) begin
               state   <= START;
               tx_line <= 1'b0;
            end
            START: if (tick) begin
               state   <= DATA;
               tx_line <= shift[0];
            end
            DATA: if (tick) begin
               if (bit_cnt != CNT_W'(DATA_W - 1)) begin
                  shift   <= shift >> 1;
                  bit_cnt <= bit_cnt + 1'b1;
                  tx_line <= shift[1];
               end else begin
                  stop_cnt <= 1'b0;
`ifdef TANK_LINK_PARITY_EN
                  state    <= PARITY;
                  tx_line  <= par;
`else
                  state    <= STOP;
                  tx_line  <= 1'b1;
`endif
               end
            end
`ifdef TANK_LINK_PARITY_EN
            PARITY: if (tick) begin
               state   <= STOP;
               tx_line <= 1'b1;
            end
`endif
            STOP: if (tick) begin
               if (stop_cnt == 1'(STOP_BITS - 1)) state <= IDLE;
               else stop_cnt <= stop_cnt + 1'b1;
            end
            default: begin
               state   <= IDLE;
               tx_line <= 1'b1;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_tank_link_tx.sv
// tb_tank_link_tx: directed self-checking bench for tank_link_tx (DATA_W=16, STOP_BITS=1, tick period 20 clk).
module tb_tank_link_tx;
`ifdef TANK_LINK_PARITY_EN
   localparam int NB = 19;
`else
   localparam int NB = 18;
`endif
   logic clk, rst, tick_clk, tx_line, busy;
   int   checks = 0, failures = 0;
   logic watch = 0;
   int   ready_seen = 0;
   tank_link_if #(.DATA_W(16)) link();
   tank_link_tx #(.DATA_W(16), .STOP_BITS(1)) dut (
      .clk(clk), .rst(rst), .tick_clk(tick_clk), .link(link), .tx_line(tx_line), .busy(busy)
   );
   initial begin clk = 0; forever #5 clk = ~clk; end
   initial begin tick_clk = 0; forever #100 tick_clk = ~tick_clk; end
   always @(negedge clk) if (watch && link.tx_ready === 1'b1) ready_seen++;
   function automatic logic [NB-1:0] exp_frame(input logic [15:0] w);
`ifdef TANK_LINK_PARITY_EN
      return {1'b1, ^w, w, 1'b0};
`else
      return {1'b1, w, 1'b0};
`endif
   endfunction
   task automatic send(input logic [15:0] w);
      int n;
      n = 0;
      while (link.tx_ready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
      checks++;
      if (link.tx_ready !== 1'b1) begin failures++; $display("FAIL send_ready: tx_ready=%b, required 1", link.tx_ready); end
      link.tx_data = w;
      link.tx_valid = 1'b1;
      @(posedge clk); #1;
      link.tx_valid = 1'b0;
   endtask
   // Finds the start bit, samples every bit at mid-period, returns at mid last stop bit.
   task automatic recv(output logic [NB-1:0] f, output int wait_cnt, output int low_len);
      bit hi;
      wait_cnt = 0;
      do begin @(negedge clk); wait_cnt++; end while (tx_line !== 1'b0 && wait_cnt < 80);
      checks++;
      if (tx_line !== 1'b0) begin failures++; $display("FAIL start_seen: tx_line=%b after %0d cycles, required 0", tx_line, wait_cnt); end
      f = '0; low_len = 0; hi = 0;
      for (int k = 1; k <= 10 + 20 * (NB - 1); k++) begin
         @(negedge clk);
         if (!hi && tx_line === 1'b1) begin hi = 1; low_len = k; end
         for (int i = 0; i < NB; i++) if (k == 10 + 20 * i) f[i] = tx_line;
      end
   endtask
   task automatic wait_idle(output int n);
      n = 0;
      while (busy !== 1'b0 && n < 60) begin @(negedge clk); n++; end
   endtask
   task automatic test_reset;
      int bad;
      rst = 1; link.tx_valid = 0; link.tx_data = '0;
      repeat (3) @(negedge clk);
      checks++;
      if ({tx_line, link.tx_ready, busy} !== 3'b110) begin failures++; $display("FAIL reset_state: line/ready/busy=%b, required 110", {tx_line, link.tx_ready, busy}); end
      @(posedge clk); #1 rst = 0;
      bad = 0;
      repeat (100) begin @(negedge clk); if ({tx_line, link.tx_ready, busy} !== 3'b110) bad++; end
      checks++;
      if (bad != 0) begin failures++; $display("FAIL reset_hold: %0d bad cycles, required 0", bad); end
   endtask
   task automatic test_frame;
      logic [NB-1:0] f; int wc, ll, n;
      send(16'hA5C3);
      recv(f, wc, ll);
      checks++;
      if (f !== exp_frame(16'hA5C3)) begin failures++; $display("FAIL frame_a5c3: got %b, required %b", f, exp_frame(16'hA5C3)); end
      checks++;
      if (ll < 19 || ll > 21) begin failures++; $display("FAIL start_len: got %0d clk, required 20+-1", ll); end
      n = 0;
      while (link.tx_ready !== 1'b1 && n < 30) begin @(negedge clk); n++; end
      checks++;
      if (link.tx_ready !== 1'b1) begin failures++; $display("FAIL ready_after_stop: got %b, required 1", link.tx_ready); end
   endtask
   task automatic test_back_to_back;
      logic [NB-1:0] f1, f2; int wc, ll, n;
      @(negedge clk);
      link.tx_data = 16'h1234; link.tx_valid = 1;
      n = 0;
      while (link.tx_ready !== 1'b1 && n < 60) begin @(negedge clk); n++; end
      @(posedge clk); #1 link.tx_data = 16'h00FF;
      recv(f1, wc, ll);
      checks++;
      if (f1 !== exp_frame(16'h1234)) begin failures++; $display("FAIL b2b_first: got %b, required %b", f1, exp_frame(16'h1234)); end
      wait_idle(n);
      checks++;
      if (link.tx_ready !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL b2b_idle_slot: ready=%b busy=%b, required 1 0", link.tx_ready, busy); end
      @(negedge clk);
      checks++;
      if (busy !== 1'b1) begin failures++; $display("FAIL b2b_accept: busy=%b one cycle after idle, required 1", busy); end
      link.tx_valid = 0;
      recv(f2, wc, ll);
      checks++;
      if (f2 !== exp_frame(16'h00FF)) begin failures++; $display("FAIL b2b_second: got %b, required %b", f2, exp_frame(16'h00FF)); end
      checks++;
      if (wc > 21) begin failures++; $display("FAIL b2b_gap: start after %0d clk, required <=21", wc); end
      wait_idle(n);
   endtask
   task automatic test_ignore_busy;
      logic [NB-1:0] f; int wc, ll, n;
      send(16'h1357);
      link.tx_data = 16'hFFFF; link.tx_valid = 1; ready_seen = 0; watch = 1;
      recv(f, wc, ll);
      link.tx_valid = 0; watch = 0;
      checks++;
      if (ready_seen != 0) begin failures++; $display("FAIL busy_ready: ready high %0d cycles, required 0", ready_seen); end
      checks++;
      if (f !== exp_frame(16'h1357)) begin failures++; $display("FAIL busy_frame: got %b, required %b", f, exp_frame(16'h1357)); end
      wait_idle(n);
   endtask
   task automatic test_mid_reset;
      logic [NB-1:0] f; int wc, ll, n;
      send(16'hC3DF);
      n = 0;
      do begin @(negedge clk); n++; end while (tx_line !== 1'b0 && n < 80);
      repeat (130) @(negedge clk);
      checks++;
      if (tx_line !== 1'b0) begin failures++; $display("FAIL mid_bit5: tx_line=%b, required 0", tx_line); end
      rst = 1;
      @(posedge clk); #1 rst = 0;
      @(negedge clk);
      checks++;
      if ({tx_line, link.tx_ready, busy} !== 3'b110) begin failures++; $display("FAIL mid_reset: line/ready/busy=%b, required 110", {tx_line, link.tx_ready, busy}); end
      send(16'h0F0F);
      recv(f, wc, ll);
      checks++;
      if (f !== exp_frame(16'h0F0F)) begin failures++; $display("FAIL after_reset_frame: got %b, required %b", f, exp_frame(16'h0F0F)); end
      wait_idle(n);
   endtask
   task automatic test_parity;
      logic [NB-1:0] f; int wc, ll, n;
      send(16'h0001);
      recv(f, wc, ll);
      wait_idle(n);
      checks++;
      if (10 + 20 * (NB - 1) + n < 20 * NB - 1 || 10 + 20 * (NB - 1) + n > 20 * NB + 1) begin
         failures++; $display("FAIL frame_len: got %0d clk, required %0d+-1", 10 + 20 * (NB - 1) + n, 20 * NB);
      end
      checks++;
      if (f[16:1] !== 16'h0001 || f[NB-1] !== 1'b1) begin failures++; $display("FAIL frame_0001: got %b", f); end
`ifdef TANK_LINK_PARITY_EN
      checks++;
      if (f[17] !== 1'b1) begin failures++; $display("FAIL parity_0001: got %b, required 1", f[17]); end
      send(16'h0003);
      recv(f, wc, ll);
      wait_idle(n);
      checks++;
      if (f[17] !== 1'b0) begin failures++; $display("FAIL parity_0003: got %b, required 0", f[17]); end
`endif
   endtask
   initial begin
      test_reset;
      test_frame;
      test_back_to_back;
      test_ignore_busy;
      test_mid_reset;
      test_parity;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
